// File: rtl/shift_pkg.sv
// Shared types and constants for the shift execution stage and its 8-bit core.
package shift_pkg;

    localparam int SHIFT_W  = 8;
    localparam int PASS_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        OUT  = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic [SHIFT_W-1:0] data;
        logic [3:0]         n;
        logic               ar;
        logic               lr;
        logic               rot;
    } shift_cmd_t;

endpackage

// File: rtl/shift_exec_stage_if.sv
// Command-in / result-out handshake bundle of the shift execution stage.
interface shift_exec_stage_if;
    import shift_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [SHIFT_W-1:0] in_data;
    logic [3:0]         in_n;
    logic               in_ar;
    logic               in_lr;
    logic               in_rot;
    logic               out_valid;
    logic               out_ready;
    logic [SHIFT_W-1:0] out_data;
    logic               busy;

    modport slave (
        input  in_valid, in_data, in_n, in_ar, in_lr, in_rot, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_n, in_ar, in_lr, in_rot, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_core.sv
// Combinational 8-bit funnel shift/rotate; amount 0..8, 8 clears (or sign-fills) a shift.
module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] i_data,
    input  logic [3:0]         i_n,
    input  logic               i_ar,
    input  logic               i_lr,
    input  logic               i_rot,
    output logic [SHIFT_W-1:0] o_data
);

    logic [SHIFT_W-1:0]   w_fill_r;
    logic [SHIFT_W-1:0]   w_fill_l;
    logic [2*SHIFT_W-1:0] w_right;
    logic [2*SHIFT_W-1:0] w_left;

    // The fill half of the funnel supplies rotate wrap bits, sign bits or zeros.
    assign w_fill_r = i_rot ? i_data : (i_ar ? {SHIFT_W{i_data[SHIFT_W-1]}} : '0);
    assign w_fill_l = i_rot ? i_data : '0;
    assign w_right  = {w_fill_r, i_data} >> i_n;
    assign w_left   = {i_data, w_fill_l} << i_n;
    assign o_data   = i_lr ? w_left[2*SHIFT_W-1:SHIFT_W] : w_right[SHIFT_W-1:0];

endmodule

// File: rtl/shift_exec_stage.sv
// Queues shift commands and runs them through shift_core, splitting amounts >8 into two passes.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    shift_exec_stage_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    shift_cmd_t         r_fifo [DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    exec_state_t        r_state;
    shift_cmd_t         r_work;
    logic               r_out_valid;
    logic [SHIFT_W-1:0] r_out_data;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    shift_cmd_t         w_cmd_in;
    shift_cmd_t         w_head;
    logic [3:0]         w_amt;
    logic [SHIFT_W-1:0] w_core_out;

    // Extra wrap bit tells full from empty when the index bits match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push   = bus.in_valid && !w_full;
    assign w_pop    = !w_empty && ((r_state == IDLE) || ((r_state == OUT) && bus.out_ready));
    assign w_cmd_in = '{data: bus.in_data, n: bus.in_n, ar: bus.in_ar,
                        lr: bus.in_lr, rot: bus.in_rot};
    assign w_head   = r_fifo[r_rd_ptr[PTR_W-1:0]];
    assign w_amt    = (r_work.n > 4'(PASS_MAX)) ? 4'(PASS_MAX) : r_work.n;

    shift_core u_core (
        .i_data (r_work.data),
        .i_n    (w_amt),
        .i_ar   (r_work.ar),
        .i_lr   (r_work.lr),
        .i_rot  (r_work.rot),
        .o_data (w_core_out)
    );

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_cmd_in;
        end
    end

    // NOTE: every register below uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_work  <= w_head;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_work.n > 4'(PASS_MAX)) begin
                        r_work.data <= w_core_out;
                        r_work.n    <= r_work.n - 4'(PASS_MAX);
                    end else begin
                        r_out_data  <= w_core_out;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (!w_empty) begin
                            r_work  <= w_head;
                            r_state <= EXEC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_shift_exec_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_exec_stage_if bus ();

    shift_exec_stage #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_out    = 0;
    logic [7:0] exp_q[$];
    bit         rand_mode   = 1'b0;
    bit         ready_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [3:0] n,
                                         input logic ar, input logic lr, input logic rot);
        logic [7:0] r = d;
        for (int k = 0; k < int'(n); k++) begin
            if (rot)     r = lr ? {r[6:0], r[7]} : {r[0], r[7:1]};
            else if (lr) r = {r[6:0], 1'b0};
            else if (ar) r = {r[7], r[7:1]};
            else         r = {1'b0, r[7:1]};
        end
        return r;
    endfunction

    // Sole driver of out_ready, updated just after each rising edge.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: handshake and stall stability are judged at the falling edge.
    initial begin
        bit         stalled = 1'b0;
        logic [7:0] held    = '0;
        forever begin
            @(negedge clk);
            if (stalled && !rst) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
        end
    end

    // Entered and left at posedge+1; the expected value is queued on the accept edge.
    task automatic send(input logic [7:0] d, input logic [3:0] n, input logic ar,
                        input logic lr, input logic rot, input logic [7:0] exp);
        bit done = 1'b0;
        int cyc  = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_n     = n;
        bus.in_ar    = ar;
        bus.in_lr    = lr;
        bus.in_rot   = rot;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                exp_q.push_back(exp);
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
            cyc++;
            #1;
        end
        bus.in_valid = 1'b0;
        check("accepted", done, 1);
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic expect_latency(input int lat);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            check($sformatf("latency_valid_%0d", i), bus.out_valid, (i == lat) ? 1 : 0);
        end
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin
        int out_before;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_n     = '0;
        bus.in_ar    = 1'b0;
        bus.in_lr    = 1'b0;
        bus.in_rot   = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single commands with latency
        send(8'hB4, 4'd2, 1'b0, 1'b0, 1'b0, 8'h2D);
        expect_latency(2);
        drain();
        send(8'h90, 4'd3, 1'b1, 1'b0, 1'b0, 8'hF2);
        expect_latency(2);
        drain();
        send(8'h81, 4'd1, 1'b0, 1'b1, 1'b1, 8'h03);
        expect_latency(2);
        drain();
        send(8'h81, 4'd12, 1'b0, 1'b0, 1'b1, 8'h18);
        expect_latency(3);
        drain();

        // Boundary amounts, back to back
        send(8'hFF, 4'd10, 1'b0, 1'b1, 1'b0, 8'h00);
        send(8'h80, 4'd15, 1'b1, 1'b0, 1'b0, 8'hFF);
        send(8'h80, 4'd8,  1'b0, 1'b0, 1'b0, 8'h00);
        send(8'h5A, 4'd0,  1'b0, 1'b0, 1'b0, 8'h5A);
        send(8'h5A, 4'd8,  1'b0, 1'b0, 1'b1, 8'h5A);
        send(8'hC1, 4'd8,  1'b1, 1'b1, 1'b0, 8'h00);
        drain();

        // Backpressure: fourth command must wait while the stage is full
        ready_force = 1'b0;
        send(8'h01, 4'd1, 1'b0, 1'b1, 1'b0, 8'h02);
        send(8'h0F, 4'd4, 1'b0, 1'b1, 1'b0, 8'hF0);
        send(8'hC3, 4'd4, 1'b0, 1'b0, 1'b1, 8'h3C);
        fork
            send(8'h70, 4'd2, 1'b1, 1'b0, 1'b0, 8'h1C);
            begin
                repeat (4) @(negedge clk);
                check("full_in_ready", bus.in_ready, 0);
                check("full_out_valid", bus.out_valid, 1);
                ready_force = 1'b1;
            end
        join
        drain();

        // Random commands with random gaps and random out_ready
        rand_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] d;
            logic [3:0] n;
            logic       ar, lr, rot;
            d   = 8'($urandom);
            n   = 4'($urandom);
            ar  = 1'($urandom);
            lr  = 1'($urandom);
            rot = 1'($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(d, n, ar, lr, rot, model(d, n, ar, lr, rot));
        end
        rand_mode = 1'b0;
        drain();

        // Reset while a two-pass command executes with two more queued
        send(8'h81, 4'd12, 1'b0, 1'b0, 1'b1, 8'h18);
        send(8'h33, 4'd1,  1'b0, 1'b1, 1'b0, 8'h66);
        send(8'h44, 4'd2,  1'b0, 1'b0, 1'b0, 8'h11);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", bus.busy, 0);
        exp_q.delete();
        out_before = n_out;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_result_after_rst", n_out, out_before);
        check("busy_after_rst", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
